// File: rtl/alu_seq_pkg.sv
// Shared types and saturation helpers for the registered ALU (alu_seq).
// The optional iterative multiplier is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND  = 4'd0,
    OP_SLT  = 4'd1,
    OP_OR   = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_BEQ  = 4'd7,
    OP_PASS = 4'd8,
    OP_MUL  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } alu_state_e;

  // Largest positive two's-complement value of a w-bit word (low w bits valid).
  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (low w bits valid).
  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add signed multiplier; the MSB partial product is subtracted
// (sign correction). Bit 0 is folded into the start cycle so done rises WIDTH-1 cycles later.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   ra,
  input  logic [WIDTH-1:0]   rb,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] sext_a;

  assign sext_a = {{WIDTH{ra[WIDTH-1]}}, ra};
  assign done   = busy && (count == CW'(WIDTH));
  assign prod   = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      count <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CW'(1);
      acc   <= rb[0] ? sext_a : '0;
      mcand <= sext_a << 1;
      mplr  <= rb >> 1;
    end else if (busy) begin
      if (count == CW'(WIDTH)) begin
        busy <= 1'b0;
      end else begin
        if (mplr[0]) begin
          acc <= (count == CW'(WIDTH - 1)) ? acc - mcand : acc + mcand;
        end
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, saturating add/sub and wide shifts.
// Define ALU_SEQ_MUL_EN to build the iterative signed multiplier for opcode 9.
module alu_seq #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    ra_in,
  input  logic [WIDTH-1:0]    rb_in,
  input  logic [OP_WIDTH-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    res_out,
  output logic [WIDTH-1:0]    car_out,
  output logic                zero,
  output logic                jump,
  output logic                illegal
);

  import alu_seq_pkg::*;

  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_neg(WIDTH));

  alu_state_e state, nxt;
  alu_op_e    op_e;
  logic       accept, is_mul, mul_done, load_alu;

  logic [WIDTH:0]     ext_a, ext_b, sum;
  logic               pos_ovf, neg_ovf, slt;
  logic [2*WIDTH-1:0] srl_word, sra_word;

  logic [WIDTH-1:0] alu_res, alu_car;
  logic             alu_jump, alu_ill;

  assign op_e     = alu_op_e'(op);
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;
  assign out_valid = (state == S_HOLD);

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (op_e == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .ra    (ra_in),
    .rb    (rb_in),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  // One extra bit makes every signed sum/difference exact, so overflow is a sign disagreement.
  assign ext_a   = {ra_in[WIDTH-1], ra_in};
  assign ext_b   = {rb_in[WIDTH-1], rb_in};
  assign sum     = (op_e == OP_SUB) ? ext_a - ext_b : ext_a + ext_b;
  assign pos_ovf = !sum[WIDTH] && sum[WIDTH-1];
  assign neg_ovf = sum[WIDTH] && !sum[WIDTH-1];
  assign slt     = $signed(ra_in) < $signed(rb_in);

  assign srl_word = {ra_in, {WIDTH{1'b0}}} >> rb_in;
  assign sra_word = $signed({ra_in, {WIDTH{1'b0}}}) >>> rb_in;

  always_comb begin
    alu_res  = '0;
    alu_car  = '0;
    alu_jump = 1'b0;
    alu_ill  = 1'b0;
    case (op_e)
      OP_AND:  alu_res = ra_in & rb_in;
      OP_SLT:  alu_res = WIDTH'(slt);
      OP_OR:   alu_res = ra_in | rb_in;
      OP_ADD, OP_SUB: begin
        if (pos_ovf) begin
          alu_res = SAT_MAX;
          alu_car = WIDTH'(1);
        end else if (neg_ovf) begin
          alu_res = SAT_MIN;
          alu_car = '1;
        end else begin
          alu_res = sum[WIDTH-1:0];
        end
      end
      OP_SRL:  {alu_res, alu_car} = srl_word;
      OP_SRA:  {alu_res, alu_car} = sra_word;
      OP_BEQ: begin
        alu_res  = ra_in ^ rb_in;
        alu_jump = (ra_in == rb_in);
      end
      OP_PASS: alu_res = ra_in;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = is_mul ? S_BUSY : S_HOLD;
      end
      S_BUSY: begin
        if (mul_done) nxt = S_HOLD;
      end
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) nxt = is_mul ? S_BUSY : S_HOLD;
          else          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      res_out <= '0;
      car_out <= '0;
      zero    <= 1'b0;
      jump    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (load_alu) begin
        res_out <= alu_res;
        car_out <= alu_car;
        zero    <= (alu_res == '0);
        jump    <= alu_jump;
        illegal <= alu_ill;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state == S_BUSY && mul_done) begin
        res_out <= mul_prod[WIDTH-1:0];
        car_out <= mul_prod[2*WIDTH-1:WIDTH];
        zero    <= (mul_prod[WIDTH-1:0] == '0);
        jump    <= 1'b0;
        illegal <= 1'b0;
      end
`endif
    end
  end

endmodule
